// File: rtl/hazard_ctrl.sv
// ============================================================================
// hazard_ctrl : 5-stage pipeline enable/flush sequencer (load-use, branch,
//               D-cache miss wait with timeout trap). Optional perf counters
//               are built when HAZARD_PERF_CNT_EN is defined.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module hazard_ctrl #(
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] inst_d_i,
   input  logic [4:0]  rsW_ex_i,
   input  logic        RegWEn_ex_i,
   input  logic [1:0]  WBSel_ex_i,
   input  logic        br_taken_ex_i,
   input  logic        Valid_cpu2cache_mem_i,
   input  logic        cache_hit_i,
   input  logic        cache_ready_i,
   output logic        en_pc_o,
   output logic        en_if_o,
   output logic        en_id_o,
   output logic        en_ex_o,
   output logic        en_mem_o,
   output logic        rst_if_o,
   output logic        rst_id_o,
   output logic [1:0]  state_o,
   output logic        timeout_err_o,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o
);

   localparam logic [1:0]  S_RUN    = 2'b00;
   localparam logic [1:0]  S_MISS   = 2'b01;
   localparam logic [1:0]  S_RESUME = 2'b10;
   localparam logic [1:0]  S_ERR    = 2'b11;
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   logic [1:0]  state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic [4:0]  rs1, rs2;
   logic        hz_miss, hz_lu;
   logic        unused_inst;

   assign rs1         = inst_d_i[19:15];
   assign rs2         = inst_d_i[24:20];
   assign unused_inst = ^{inst_d_i[31:25], inst_d_i[14:0]};

   assign hz_miss = Valid_cpu2cache_mem_i & ~cache_hit_i;
   assign hz_lu   = RegWEn_ex_i & (WBSel_ex_i == 2'b00) & (rsW_ex_i != 5'd0) &
                    ((rsW_ex_i == rs1) | (rsW_ex_i == rs2));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_RUN;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_RUN: begin
            if (hz_miss) begin
               state_d = S_MISS;
               cnt_d   = '0;
            end
         end
         S_MISS: begin
            // Ready takes precedence over the timeout in the same cycle
            if (cache_ready_i)          state_d = S_RESUME;
            else if (cnt_q == CNT_LAST) state_d = S_ERR;
            else                        cnt_d   = cnt_q + 16'd1;
         end
         S_RESUME: state_d = S_RUN;
         S_ERR:    state_d = S_ERR;
         default:  state_d = S_RUN;
      endcase
   end

   always_comb begin
      en_pc_o  = 1'b0;
      en_if_o  = 1'b0;
      en_id_o  = 1'b0;
      en_ex_o  = 1'b0;
      en_mem_o = 1'b0;
      rst_if_o = 1'b0;
      rst_id_o = 1'b0;
      if (state_q == S_RUN && !hz_miss) begin
         en_pc_o  = 1'b1;
         en_if_o  = 1'b1;
         en_id_o  = 1'b1;
         en_ex_o  = 1'b1;
         en_mem_o = 1'b1;
         if (br_taken_ex_i) begin
            rst_if_o = 1'b1;
            rst_id_o = 1'b1;
         end else if (hz_lu) begin
            // Hold PC and IF/ID, inject a bubble into ID/EX
            en_pc_o  = 1'b0;
            en_if_o  = 1'b0;
            rst_id_o = 1'b1;
         end
      end
   end

   assign state_o       = state_q;
   assign timeout_err_o = (state_q == S_ERR);

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (!en_pc_o && stall_cnt_q != 32'hFFFF_FFFF)
            stall_cnt_q <= stall_cnt_q + 32'd1;
         if (rst_if_o && flush_cnt_q != 32'hFFFF_FFFF)
            flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;
`else
   assign stall_cnt_o = 32'h0;
   assign flush_cnt_o = 32'h0;
`endif

endmodule

`default_nettype wire
